// File: rtl/regs_pkg.sv
// Shared definitions for the regs register file and its write-port arbiter.
package regs_pkg;

  localparam int REGS_AW  = 8;
  localparam int REGS_DW  = 64;
  localparam int REGS_NRD = 4;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_LD  = 2'd1,
    WB_MUL = 2'd2
  } wb_src_t;

  typedef struct packed {
    logic [REGS_AW-1:0] addr;
    logic [REGS_DW-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping modulo N.
module rr_arbiter #(
  parameter int N = 3,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          any
);

  always_comb begin
    int j;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!any && req[j]) begin
        gnt[j] = 1'b1;
        idx    = PW'(j);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regs_wr_arb.sv
// Shares the single regs write port among writeback sources; registers the winner and
// flags operand-fetch reads that collide with the write committing at the next edge.
module regs_wr_arb
  import regs_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int AW   = REGS_AW,
  parameter int DW   = REGS_DW,
  parameter int NCHK = REGS_NRD
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ-1:0][AW-1:0]    req_addr,
  input  logic [NREQ-1:0][DW-1:0]    req_data,
  output logic                       we,
  output logic [AW-1:0]              wa,
  output logic [DW-1:0]              wd,
  input  logic [NCHK-1:0][AW-1:0]    chk_addr,
  output logic [NCHK-1:0]            chk_hit,
  output logic [1:0]                 grant_id
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   ptr_q, ptr_d;
  logic            we_q, we_d;
  logic [AW-1:0]   wa_q, wa_d;
  logic [DW-1:0]   wd_q, wd_d;
  logic [1:0]      gid_q, gid_d;

  logic [NREQ-1:0] gnt;
  logic [PW-1:0]   win_idx;
  logic            win_any;

  rr_arbiter #(.N(NREQ)) u_arb (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (win_idx),
    .any (win_any)
  );

  // Handshake: a requester transfers in any cycle where req_valid[i] & req_ready[i];
  // ready is offered only to the round-robin winner and only outside reset.
  assign req_ready = gnt & {NREQ{reset_n}};

  always_comb begin
    ptr_d = ptr_q;
    we_d  = 1'b0;
    wa_d  = wa_q;
    wd_d  = wd_q;
    gid_d = gid_q;
    if (win_any) begin
      we_d  = 1'b1;
      wa_d  = req_addr[win_idx];
      wd_d  = req_data[win_idx];
      gid_d = 2'(win_idx);
      ptr_d = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
      we_q  <= 1'b0;
      wa_q  <= '0;
      wd_q  <= '0;
      gid_q <= 2'(WB_ALU);
    end else begin
      ptr_q <= ptr_d;
      we_q  <= we_d;
      wa_q  <= wa_d;
      wd_q  <= wd_d;
      gid_q <= gid_d;
    end
  end

  // Only the registered write is compared; requests being granted this cycle are not visible yet.
  always_comb begin
    chk_hit = '0;
    for (int k = 0; k < NCHK; k++) begin
      chk_hit[k] = we_q && (wa_q == chk_addr[k]);
    end
  end

  assign we       = we_q;
  assign wa       = wa_q;
  assign wd       = wd_q;
  assign grant_id = gid_q;

endmodule

// File: tb/tb_regs_wr_arb.sv
// Bench for regs_wr_arb: directed scenarios plus randomized traffic against a behavioural model.
module tb_regs_wr_arb;

  localparam int NREQ = 3;
  localparam int AW   = 8;
  localparam int DW   = 64;
  localparam int NCHK = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ-1:0][AW-1:0] req_addr;
  logic [NREQ-1:0][DW-1:0] req_data;
  logic                    we;
  logic [AW-1:0]           wa;
  logic [DW-1:0]           wd;
  logic [NCHK-1:0][AW-1:0] chk_addr;
  logic [NCHK-1:0]         chk_hit;
  logic [1:0]              grant_id;

  regs_wr_arb #(.NREQ(NREQ), .AW(AW), .DW(DW), .NCHK(NCHK)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .we        (we),
    .wa        (wa),
    .wd        (wd),
    .chk_addr  (chk_addr),
    .chk_hit   (chk_hit),
    .grant_id  (grant_id)
  );

  // Stand-in for the downstream register file.
  logic [DW-1:0] regs_mem [0:255] = '{default: 64'h0};
  always @(posedge clk) if (we) regs_mem[wa] <= wd;

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: priority list starting at the pointer, first valid wins.
  int            m_ptr = 0;
  logic          m_we  = 1'b0;
  logic [AW-1:0] m_wa  = '0;
  logic [DW-1:0] m_wd  = '0;
  int            m_gid = 0;
  int            m_win;
  logic [NREQ-1:0] exp_ready;
  logic [NCHK-1:0] exp_hit;

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    if (!reset_n) begin
      check("rst_ready", 64'(req_ready), 64'h0);
      check("rst_we", 64'(we), 64'h0);
      check("rst_wa", 64'(wa), 64'h0);
      check("rst_wd", wd, 64'h0);
      check("rst_gid", 64'(grant_id), 64'h0);
      check("rst_hit", 64'(chk_hit), 64'h0);
      m_ptr = 0; m_we = 1'b0; m_wa = '0; m_wd = '0; m_gid = 0;
    end else begin
      m_win     = rr_pick(req_valid, m_ptr);
      exp_ready = (m_win >= 0) ? (NREQ'(1) << m_win) : '0;
      for (int k = 0; k < NCHK; k++) exp_hit[k] = m_we && (m_wa == chk_addr[k]);
      check("ready", 64'(req_ready), 64'(exp_ready));
      check("we", 64'(we), 64'(m_we));
      check("wa", 64'(wa), 64'(m_wa));
      check("wd", wd, m_wd);
      check("grant_id", 64'(grant_id), 64'(m_gid));
      check("chk_hit", 64'(chk_hit), 64'(exp_hit));
      if (m_win >= 0) begin
        m_we  = 1'b1;
        m_wa  = req_addr[m_win];
        m_wd  = req_data[m_win];
        m_gid = m_win;
        m_ptr = (m_win + 1) % NREQ;
      end else begin
        m_we = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  int exp_seq [6] = '{0, 1, 2, 0, 1, 2};
  logic [NREQ-1:0] acc;

  initial begin
    reset_n   = 1'b0;
    req_valid = 3'b111;
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i] = 8'(8'h40 + i);
      req_data[i] = 64'(64'hcafe0000 + i);
    end
    for (int k = 0; k < NCHK; k++) chk_addr[k] = '0;

    // Reset held two cycles with everyone requesting.
    @(negedge clk);
    @(negedge clk);
    check("lit_rst_ready", 64'(req_ready), 64'h0);
    check("lit_rst_we", 64'(we), 64'h0);
    step();
    reset_n = 1'b1;
    @(negedge clk);
    check("lit_first_ready", 64'(req_ready), 64'b001);
    step();
    req_valid = '0;
    step();

    // Single write from the load unit.
    req_valid   = 3'b010;
    req_addr[1] = 8'h05;
    req_data[1] = 64'hdeadbeef00000002;
    @(negedge clk);
    check("lit_single_ready", 64'(req_ready), 64'b010);
    step();
    req_valid = '0;
    @(negedge clk);
    check("lit_single_we", 64'(we), 64'h1);
    check("lit_single_wa", 64'(wa), 64'h05);
    check("lit_single_wd", wd, 64'hdeadbeef00000002);
    step();
    @(negedge clk);
    check("lit_single_regs", regs_mem[5], 64'hdeadbeef00000002);

    // Full contention: grants rotate from 0.
    do_reset();
    req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      step();
      if (k == 5) req_valid = '0;
      @(negedge clk);
      check("lit_rot_gid", 64'(grant_id), 64'(exp_seq[k]));
      check("lit_rot_we", 64'(we), 64'h1);
    end

    // Hazard check against a write to 3.
    step();
    req_valid   = 3'b001;
    req_addr[0] = 8'h03;
    req_data[0] = 64'h33;
    chk_addr[0] = 8'd3; chk_addr[1] = 8'd1; chk_addr[2] = 8'd3; chk_addr[3] = 8'd7;
    step();
    req_valid = '0;
    @(negedge clk);
    check("lit_hazard_hit", 64'(chk_hit), 64'b0101);
    step();
    @(negedge clk);
    check("lit_hazard_idle", 64'(chk_hit), 64'b0000);

    // Reset while a write is in flight.
    step();
    req_valid   = 3'b001;
    req_addr[0] = 8'h20;
    req_data[0] = 64'h1234;
    step();
    req_valid = '0;
    check("lit_pre_rst_we", 64'(we), 64'h1);
    reset_n = 1'b0;
    #1;
    check("lit_async_we", 64'(we), 64'h0);
    step();
    step();
    reset_n     = 1'b1;
    req_valid   = 3'b110;
    req_addr[1] = 8'h30; req_data[1] = 64'h30;
    req_addr[2] = 8'h31; req_data[2] = 64'h31;
    @(negedge clk);
    check("lit_post_rst_ready", 64'(req_ready), 64'b010);
    check("lit_dropped_write", regs_mem[8'h20], 64'h0);
    step();
    req_valid = '0;
    step();

    // Same address from ALU then load: the later write lands.
    do_reset();
    req_valid   = 3'b011;
    req_addr[0] = 8'h10; req_data[0] = 64'hdeadbeef00000001;
    req_addr[1] = 8'h10; req_data[1] = 64'hdeadbeef00000002;
    step();
    req_valid = 3'b010;
    step();
    req_valid = '0;
    step();
    @(negedge clk);
    check("lit_same_addr", regs_mem[8'h10], 64'hdeadbeef00000002);

    // Randomized traffic; pending requests hold addr/data until accepted or dropped.
    for (int it = 0; it < 400; it++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      step();
      if (it == 200) reset_n = 1'b0;
      if (it == 202) reset_n = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && !acc[i]) begin
          if ($urandom_range(0, 7) == 0) req_valid[i] = 1'b0;
        end else begin
          req_valid[i] = ($urandom_range(0, 3) != 0);
          req_addr[i]  = 8'($urandom_range(0, 7));
          req_data[i]  = {$urandom, $urandom};
        end
      end
      for (int k = 0; k < NCHK; k++) chk_addr[k] = 8'($urandom_range(0, 7));
    end
    req_valid = '0;
    step();
    @(negedge clk);

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
